// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared state, funct3 encodings and access-size helpers for the MEM stage
package riscv_mem_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int TIMEOUT_CYCLES_DEF = 255;
    function automatic logic is_byte(input logic [2:0] f3);
        return f3 == F3_B || f3 == F3_BU;
    endfunction
    function automatic logic is_half(input logic [2:0] f3);
        return f3 == F3_H || f3 == F3_HU;
    endfunction
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/halfword of a read word and sign- or zero-extends it
module load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = rdata[{addr, 3'b000} +: 8];
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        data = funct3 == F3_B  ? {{24{b[7]}}, b} :
               funct3 == F3_H  ? {{16{h[15]}}, h} :
               funct3 == F3_BU ? {24'b0, b} :
               funct3 == F3_HU ? {16'b0, h} : rdata;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I MEM stage with req/ack data memory; MEM_MISALIGN_TRAP_EN traps misaligned accesses
module mem_access_stage
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  funct3_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_out,
    output logic [31:0] data_out,
    output logic [31:0] alu_out,
    output logic [4:0]  rd_out,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic        bus_err_out,
    output logic        misalign_out
);
    state_t      state_q, state_d;
    logic        req_q, req_d, we_q, we_d, err_q, err_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d, ld_ext;
    logic [3:0]  be_q, be_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  off;
    logic        mem_op, hw, wd, trap, issue, ack, tmo;

    assign mem_op = valid_in && (MemRead_in || MemWrite_in);
    assign hw     = is_half(funct3_in);
    assign wd     = !is_byte(funct3_in) && !hw;
    // Offset after forcing natural alignment; drives both byte enables and load lane select
    assign off    = wd ? 2'b00 : hw ? {alu_in[1], 1'b0} : alu_in[1:0];
`ifdef MEM_MISALIGN_TRAP_EN
    assign trap   = (hw && alu_in[0]) || (wd && alu_in[1:0] != 2'b00);
`else
    assign trap   = 1'b0;
`endif
    assign issue  = state_q == IDLE && mem_op && !trap;
    assign ack    = state_q == REQ && dmem_ack;
    assign tmo    = state_q == REQ && !dmem_ack && cnt_q == 8'(TIMEOUT_CYCLES - 1);

    load_align u_align (
        .rdata  (dmem_rdata),
        .addr   (off),
        .funct3 (funct3_in),
        .data   (ld_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = issue ? REQ : (ack || tmo) ? RESP : state_q == RESP ? IDLE : state_q;
    end

    always_comb begin
        req_d   = issue || (req_q && !ack && !tmo);
        we_d    = issue ? MemWrite_in : (ack || tmo) ? 1'b0 : we_q;
        addr_d  = issue ? {alu_in[31:2], 2'b00} : addr_q;
        be_d    = issue ? (wd ? 4'b1111 : (hw ? 4'b0011 : 4'b0001) << off) : be_q;
        wdata_d = !issue ? wdata_q : wd ? store_data_in :
                  hw ? {2{store_data_in[15:0]}} : {4{store_data_in[7:0]}};
        cnt_d   = issue ? 8'd0 : state_q == REQ ? cnt_q + 8'd1 : cnt_q;
        ld_d    = ack ? (we_q ? 32'd0 : ld_ext) : tmo ? 32'd0 : ld_q;
        err_d   = tmo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            ld_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        stall_out    = !reset && (issue || state_q == REQ);
        misalign_out = !reset && state_q == IDLE && mem_op && trap;
        RegWrite_out = RegWrite_in && !reset && !stall_out && !misalign_out && !err_q;
        data_out     = state_q == RESP ? ld_q : 32'd0;
        bus_err_out  = err_q;
        dmem_req     = req_q;
        dmem_we      = we_q;
        dmem_addr    = addr_q;
        dmem_be      = be_q;
        dmem_wdata   = wdata_q;
        alu_out      = alu_in;
        rd_out       = rd_in;
        MemtoReg_out = MemtoReg_in;
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized self-checking bench against a byte-lane reference model
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] alu_in = '0;
    logic [31:0] store_data_in = '0;
    logic [4:0]  rd_in = '0;
    logic [2:0]  funct3_in = '0;
    logic        MemRead_in = 1'b0;
    logic        MemWrite_in = 1'b0;
    logic        RegWrite_in = 1'b0;
    logic        MemtoReg_in = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        dmem_req, dmem_we, stall_out, RegWrite_out, MemtoReg_out, bus_err_out, misalign_out;
    logic [31:0] dmem_addr, dmem_wdata, data_out, alu_out;
    logic [3:0]  dmem_be;
    logic [4:0]  rd_out;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .alu_in(alu_in),
        .store_data_in(store_data_in), .rd_in(rd_in), .funct3_in(funct3_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .RegWrite_in(RegWrite_in),
        .MemtoReg_in(MemtoReg_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall_out(stall_out),
        .data_out(data_out), .alu_out(alu_out), .rd_out(rd_out),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .bus_err_out(bus_err_out), .misalign_out(misalign_out)
    );

    // Access width in bytes; funct3 values outside B/H/BU/HU behave as a word
    function automatic int sz(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    endfunction

    function automatic int aoff(input logic [31:0] a, input logic [2:0] f3);
        return (int'(a[1:0]) / sz(f3)) * sz(f3);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdv, input logic [31:0] a, input logic [2:0] f3);
        int n = sz(f3);
        logic [31:0] mask, v;
        if (n == 4) return rdv;
        mask = (32'h1 << (8 * n)) - 32'h1;
        v = (rdv >> (8 * aoff(a, f3))) & mask;
        if ((f3 == 3'b000 || f3 == 3'b001) && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f3);
        logic [3:0] be;
        for (int i = 0; i < 4; i++) be[i] = i >= aoff(a, f3) && i < aoff(a, f3) + sz(f3);
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [31:0] sd, input logic [2:0] f3);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8 * i +: 8] = sd[8 * (i % sz(f3)) +: 8];
        return w;
    endfunction

    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rdv, input int delay);
        logic [31:0] eld = st ? 32'd0 : m_load(rdv, a, f3);
        logic [3:0]  ebe = m_be(a, f3);
        logic [31:0] ewd = m_wd(sd, f3);
        logic [4:0]  rdn = 5'($urandom);
        @(negedge clk);
        valid_in = 1'b1; MemRead_in = !st; MemWrite_in = st; RegWrite_in = !st; MemtoReg_in = !st;
        alu_in = a; funct3_in = f3; store_data_in = sd; rd_in = rdn; dmem_ack = 1'b0;
        #1 total++;
        if ({stall_out, dmem_req, RegWrite_out, misalign_out} !== 4'b1000)
            $display("FAIL issue_ctl a=%h f3=%0d got=%b want=1000", a, f3, {stall_out, dmem_req, RegWrite_out, misalign_out});
        else passed++;
        for (int k = 0; k <= delay; k++) begin
            @(negedge clk);
            dmem_ack = k == delay;
            dmem_rdata = k == delay ? rdv : $urandom;
            #1 total++;
            if ({dmem_req, dmem_we, stall_out, RegWrite_out} !== {1'b1, st, 1'b1, 1'b0})
                $display("FAIL req_ctl a=%h cyc=%0d got=%b want=%b", a, k, {dmem_req, dmem_we, stall_out, RegWrite_out}, {1'b1, st, 2'b10});
            else passed++;
            total++;
            if ({dmem_addr, dmem_be} !== {a & ~32'h3, ebe})
                $display("FAIL req_addr_be a=%h f3=%0d got=%h/%b want=%h/%b", a, f3, dmem_addr, dmem_be, a & ~32'h3, ebe);
            else passed++;
            if (st) begin
                total++;
                if (dmem_wdata !== ewd) $display("FAIL req_wdata a=%h f3=%0d got=%h want=%h", a, f3, dmem_wdata, ewd);
                else passed++;
            end
        end
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        #1 total++;
        if ({stall_out, dmem_req, dmem_we, RegWrite_out, bus_err_out} !== {3'b000, !st, 1'b0})
            $display("FAIL resp_ctl a=%h got=%b want=%b", a, {stall_out, dmem_req, dmem_we, RegWrite_out, bus_err_out}, {3'b000, !st, 1'b0});
        else passed++;
        total++;
        if (data_out !== eld) $display("FAIL resp_data a=%h f3=%0d rdata=%h got=%h want=%h", a, f3, rdv, data_out, eld);
        else passed++;
        total++;
        if ({alu_out, rd_out, MemtoReg_out} !== {a, rdn, !st})
            $display("FAIL resp_pass got=%h/%h/%b want=%h/%h/%b", alu_out, rd_out, MemtoReg_out, a, rdn, !st);
        else passed++;
        @(negedge clk);
        valid_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
        #1 total++;
        if ({stall_out, dmem_req, data_out} !== 34'd0)
            $display("FAIL post_idle got=%b/%b/%h want=0/0/0", stall_out, dmem_req, data_out);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b1; MemRead_in = 1'b1; RegWrite_in = 1'b1;
        repeat (2) @(negedge clk);
        #1 total++;
        if ({stall_out, RegWrite_out, misalign_out, dmem_req, dmem_we, bus_err_out} !== 6'd0)
            $display("FAIL reset_ctl got=%b want=000000", {stall_out, RegWrite_out, misalign_out, dmem_req, dmem_we, bus_err_out});
        else passed++;
        total++;
        if ({dmem_addr, dmem_wdata, dmem_be, data_out} !== 100'd0)
            $display("FAIL reset_data got=%h/%h/%b/%h want=0", dmem_addr, dmem_wdata, dmem_be, data_out);
        else passed++;
        @(negedge clk);
        reset = 1'b0; valid_in = 1'b0; MemRead_in = 1'b0;
    endtask

    task automatic test_nonmem();
        logic [31:0] a;
        logic [4:0]  r;
        logic        rw, m2r;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a = i == 0 ? 32'h1234 : $urandom; r = 5'($urandom); rw = i == 0 ? 1'b1 : 1'($urandom); m2r = 1'($urandom);
            valid_in = i[0]; MemRead_in = !i[0] && 1'($urandom); MemWrite_in = !i[0] && 1'($urandom);
            alu_in = a; rd_in = r; RegWrite_in = rw; MemtoReg_in = m2r; funct3_in = 3'($urandom);
            #1 total++;
            if ({stall_out, dmem_req, misalign_out, data_out} !== 35'd0)
                $display("FAIL nonmem_ctl i=%0d got=%b/%b/%b/%h want=0", i, stall_out, dmem_req, misalign_out, data_out);
            else passed++;
            total++;
            if ({alu_out, rd_out, RegWrite_out, MemtoReg_out} !== {a, r, rw, m2r})
                $display("FAIL nonmem_pass i=%0d got=%h/%h/%b/%b want=%h/%h/%b/%b", i, alu_out, rd_out, RegWrite_out, MemtoReg_out, a, r, rw, m2r);
            else passed++;
        end
        @(negedge clk);
        valid_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
    endtask

    task automatic test_load();
        logic [31:0] a;
        logic [2:0]  f3;
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF12, 1);
        for (int i = 0; i < 12; i++) begin
            a = $urandom; f3 = 3'($urandom_range(0, 7));
`ifdef MEM_MISALIGN_TRAP_EN
            a[1:0] = 2'(aoff(a, f3));
`endif
            run_op(1'b0, f3, a, $urandom, $urandom, $urandom_range(0, 3));
        end
    endtask

    task automatic test_store();
        logic [31:0] a;
        logic [2:0]  f3;
        run_op(1'b1, 3'b001, 32'h102, 32'hAAAA_BEEF, 32'h0, 0);
        for (int i = 0; i < 10; i++) begin
            a = $urandom; f3 = 3'($urandom_range(0, 2));
`ifdef MEM_MISALIGN_TRAP_EN
            a[1:0] = 2'(aoff(a, f3));
`endif
            run_op(1'b1, f3, a, $urandom, $urandom, $urandom_range(0, 3));
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        valid_in = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b0; RegWrite_in = 1'b1;
        funct3_in = 3'b010; alu_in = $urandom & ~32'h3; dmem_ack = 1'b0;
        #1 total++;
        if (stall_out !== 1'b1) $display("FAIL tmo_issue stall got=%b want=1", stall_out);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            dmem_rdata = $urandom;
            #1 total++;
            if ({dmem_req, stall_out, bus_err_out} !== 3'b110)
                $display("FAIL tmo_wait cyc=%0d got=%b want=110", k, {dmem_req, stall_out, bus_err_out});
            else passed++;
        end
        @(negedge clk);
        dmem_ack = 1'b1;
        #1 total++;
        if ({dmem_req, stall_out, bus_err_out, RegWrite_out} !== 4'b0010)
            $display("FAIL tmo_resp got=%b want=0010", {dmem_req, stall_out, bus_err_out, RegWrite_out});
        else passed++;
        total++;
        if (data_out !== 32'd0) $display("FAIL tmo_data got=%h want=0", data_out);
        else passed++;
        @(negedge clk);
        valid_in = 1'b0; MemRead_in = 1'b0; dmem_ack = 1'b0;
        #1 total++;
        if ({bus_err_out, stall_out, dmem_req, data_out} !== 35'd0)
            $display("FAIL tmo_after got=%b/%b/%b/%h want=0", bus_err_out, stall_out, dmem_req, data_out);
        else passed++;
    endtask

    task automatic test_reset_mid_req();
        @(negedge clk);
        valid_in = 1'b1; MemRead_in = 1'b1; RegWrite_in = 1'b1; funct3_in = 3'b010; alu_in = 32'h200;
        #1;
        @(negedge clk);
        #1 total++;
        if ({dmem_req, stall_out} !== 2'b11) $display("FAIL rst_req got=%b want=11", {dmem_req, stall_out});
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        #1 total++;
        if ({stall_out, RegWrite_out} !== 2'b00) $display("FAIL rst_forced got=%b want=00", {stall_out, RegWrite_out});
        else passed++;
        @(negedge clk);
        reset = 1'b0; valid_in = 1'b0; MemRead_in = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        #1 total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, bus_err_out, stall_out, data_out} !== 105'd0)
            $display("FAIL rst_clear got=%b/%b/%h/%h/%b/%b/%b/%h want=0", dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, bus_err_out, stall_out, data_out);
        else passed++;
        @(negedge clk);
        dmem_ack = 1'b0;
        #1 total++;
        if ({dmem_req, stall_out, bus_err_out, data_out} !== 35'd0)
            $display("FAIL rst_ack_ignored got=%b/%b/%b/%h want=0", dmem_req, stall_out, bus_err_out, data_out);
        else passed++;
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
        logic [31:0] addrs [2] = '{32'h102, 32'h101};
        logic [2:0]  f3s [2] = '{3'b010, 3'b001};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            valid_in = 1'b1; MemRead_in = 1'b1; RegWrite_in = 1'b1; alu_in = addrs[i]; funct3_in = f3s[i];
            #1 total++;
            if ({misalign_out, stall_out, RegWrite_out, dmem_req} !== 4'b1000)
                $display("FAIL trap i=%0d got=%b want=1000", i, {misalign_out, stall_out, RegWrite_out, dmem_req});
            else passed++;
            @(negedge clk);
            valid_in = 1'b0; MemRead_in = 1'b0;
            #1 total++;
            if ({misalign_out, dmem_req, stall_out} !== 3'b000)
                $display("FAIL trap_after i=%0d got=%b want=000", i, {misalign_out, dmem_req, stall_out});
            else passed++;
        end
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h7F00_0000, 0);
`else
        run_op(1'b0, 3'b010, 32'h102, 32'h0, 32'hDEAD_BEEF, 0);
        run_op(1'b0, 3'b001, 32'h103, 32'h0, 32'h8001_7F02, 2);
        run_op(1'b1, 3'b010, 32'h303, 32'h1234_5678, 32'h0, 1);
        total++;
        if (misalign_out !== 1'b0) $display("FAIL misalign_tied got=%b want=0", misalign_out);
        else passed++;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nonmem();
        test_load();
        test_store();
        test_timeout();
        test_reset_mid_req();
        test_misalign();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
